// File: rtl/sha2_pkg.sv
// sha2_pkg -- shared SHA-2 (256/224) definitions.
// Contents: FSM state encoding, the 64 round constants K, the SHA-256 and
// SHA-224 initial hash values, and the rotate/Sigma/sigma helper functions
// used by the round logic and the message schedule.
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COMP  = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam logic [31:0] SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] SHA256_IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] SHA224_IV [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// sha2_round -- one combinational SHA-256 compression round.
// Ports: a_i..h_i working variables in, k_i round constant, w_i schedule
// word; a_o..h_o working variables after the round.
module sha2_round
  import sha2_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] e_i,
  input  logic [31:0] f_i,
  input  logic [31:0] g_i,
  input  logic [31:0] h_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic [31:0] e_o,
  output logic [31:0] f_o,
  output logic [31:0] g_o,
  output logic [31:0] h_o
);

  logic [31:0] ch_v, maj_v, t1, t2;

  always_comb begin
    ch_v  = (e_i & f_i) ^ (~e_i & g_i);
    maj_v = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
    t1    = h_i + big_sigma1(e_i) + ch_v + k_i + w_i;
    t2    = big_sigma0(a_i) + maj_v;
  end

  assign a_o = t1 + t2;
  assign b_o = a_i;
  assign c_o = b_i;
  assign d_o = c_i;
  assign e_o = d_i + t1;
  assign f_o = e_i;
  assign g_o = f_i;
  assign h_o = g_i;

endmodule

// File: rtl/sha256_core_gen.sv
// sha256_core_gen -- iterative SHA-256 (optionally SHA-224) block core.
// Parameter ROUNDS_PER_CYCLE (1, 2 or 4) sets rounds chained per clock.
// Ports: clk, rst_n (async active-low); in_valid/in_ready block handshake
// with block_in (word 0 at [511:480]), first (start from IV), last (final
// block), mode_224 (SHA-224, sampled with first=1); abort (synchronous
// cancel, clears H); out_valid/out_ready digest handshake; digest = H0..H7,
// H0 at [255:224].
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high; the producer holds its payload stable while valid is high and
// ready is low.
// Build option: define SHA256_CORE_GEN_SHA224_EN to include SHA-224 support;
// otherwise mode_224 is ignored.
module sha256_core_gen
  import sha2_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic         first,
  input  logic         last,
  input  logic         mode_224,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);

  localparam int R      = ROUNDS_PER_CYCLE;
  localparam int CYCLES = 64 / R;

  if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
    $error("sha256_core_gen: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic [31:0] h_q [0:7];
  logic [31:0] h_d [0:7];
  logic [31:0] wv_q [0:7];
  logic [31:0] wv_d [0:7];
  logic [31:0] w_q [0:15];
  logic [31:0] w_d [0:15];
  logic [31:0] iv_new [0:7];   // IV for a block being accepted now
  logic [31:0] iv_held [0:7];  // IV of the message currently in flight
  logic        mode_q;

`ifdef SHA256_CORE_GEN_SHA224_EN
  logic mode_d;
`else
  logic unused_mode;
  assign unused_mode = mode_224;
  assign mode_q      = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      iv_new[i]  = SHA256_IV[i];
      iv_held[i] = SHA256_IV[i];
`ifdef SHA256_CORE_GEN_SHA224_EN
      if (mode_224) iv_new[i]  = SHA224_IV[i];
      if (mode_q)   iv_held[i] = SHA224_IV[i];
`endif
    end
  end

  // Round chain: rs[0] is the registered state, rs[R] the state after R rounds.
  // The window w_q always starts at the current round's word, so round j of
  // this cycle simply uses w_q[j].
  logic [31:0] rs [0:R][0:7];

  for (genvar i = 0; i < 8; i++) begin : g_rs0
    assign rs[0][i] = wv_q[i];
  end

  for (genvar j = 0; j < R; j++) begin : g_round
    logic [5:0] k_idx;
    assign k_idx = 6'(int'(cnt_q) * R + j);
    sha2_round u_round (
      .a_i(rs[j][0]), .b_i(rs[j][1]), .c_i(rs[j][2]), .d_i(rs[j][3]),
      .e_i(rs[j][4]), .f_i(rs[j][5]), .g_i(rs[j][6]), .h_i(rs[j][7]),
      .k_i(SHA256_K[k_idx]), .w_i(w_q[j]),
      .a_o(rs[j+1][0]), .b_o(rs[j+1][1]), .c_o(rs[j+1][2]), .d_o(rs[j+1][3]),
      .e_o(rs[j+1][4]), .f_o(rs[j+1][5]), .g_o(rs[j+1][6]), .h_o(rs[j+1][7])
    );
  end

  // 16-word schedule window extended by R freshly expanded words; later new
  // words may depend on earlier ones from the same cycle (R=4).
  logic [31:0] sched_ext [0:15+R];

  always_comb begin
    for (int i = 0; i < 16; i++) sched_ext[i] = w_q[i];
    for (int k = 0; k < R; k++) begin
      sched_ext[16+k] = small_sigma1(sched_ext[14+k]) + sched_ext[9+k]
                      + small_sigma0(sched_ext[1+k]) + sched_ext[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    last_d      = last_q;
    h_d         = h_q;
    wv_d        = wv_q;
    w_d         = w_q;
`ifdef SHA256_CORE_GEN_SHA224_EN
    mode_d      = mode_q;
`endif
    if (abort) begin
      state_d     = IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < 8; i++) h_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_d = COMP;
            cnt_d   = '0;
            first_d = first;
            last_d  = last;
`ifdef SHA256_CORE_GEN_SHA224_EN
            if (first) mode_d = mode_224;
`endif
            for (int i = 0; i < 16; i++) w_d[i] = block_in[511-32*i -: 32];
            for (int i = 0; i < 8; i++) wv_d[i] = first ? iv_new[i] : h_q[i];
          end
        end
        COMP: begin
          for (int i = 0; i < 8; i++) wv_d[i] = rs[R][i];
          for (int i = 0; i < 16; i++) w_d[i] = sched_ext[i+R];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(CYCLES - 1)) state_d = FINAL;
        end
        FINAL: begin
          // H stays untouched until here so digest only moves in FINAL;
          // a first block adds onto the IV instead of the held H.
          for (int i = 0; i < 8; i++) h_d[i] = (first_q ? iv_held[i] : h_q[i]) + wv_q[i];
          state_d = last_q ? OUT : IDLE;
        end
        OUT: begin
          // out_valid rises one cycle after entering OUT.
          if (out_valid_q && out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            out_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]  <= '0;
        wv_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
`ifdef SHA256_CORE_GEN_SHA224_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      h_q         <= h_d;
      wv_q        <= wv_d;
      w_q         <= w_d;
`ifdef SHA256_CORE_GEN_SHA224_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) digest[255-32*i -: 32] = h_q[i];
    if (mode_q) digest[31:0] = '0;
  end

endmodule

// File: tb/tb_sha256_core_gen.sv
// tb_sha256_core_gen -- directed scoreboard bench for sha256_core_gen.
// Three instances (ROUNDS_PER_CYCLE 1, 2, 4) share clock and reset; only one
// is driven at a time, so a single expected queue serves all of them.
module tb_sha256_core_gen;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B1_BLK = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2_BLK = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO256 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_CORE_GEN_SHA224_EN
  localparam logic [255:0] ABC_M224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
`else
  localparam logic [255:0] ABC_M224 = ABC256;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid [3];
  logic         in_ready [3];
  logic [511:0] block_s [3];
  logic         first_s [3];
  logic         last_s [3];
  logic         mode_s [3];
  logic         abort_s [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [255:0] digest_s [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256_core_gen #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .block_in(block_s[g]),
      .first(first_s[g]), .last(last_s[g]), .mode_224(mode_s[g]), .abort(abort_s[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .digest(digest_s[g])
    );
  end

  // ---------------- scoreboard state ----------------
  logic [255:0] exp_q [$];
  int           lat_q [$];
  int           dut_q [$];
  int           n_vec = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           xfer_cyc [3];
  logic         ov_prev [3];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle counter and transfer timestamps (inputs are stable at posedge).
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 3; g++)
      if (in_valid[g] && in_ready[g] && !abort_s[g]) xfer_cyc[g] = cyc;
  end

  // Monitor: on each rising out_valid, pop and compare digest and latency.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (out_valid[g] === 1'b1 && ov_prev[g] !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_out dut%0d: got digest %h expected no output", g, digest_s[g]);
        end else begin
          logic [255:0] e_d;
          int           e_l;
          int           e_g;
          e_d = exp_q.pop_front();
          e_l = lat_q.pop_front();
          e_g = dut_q.pop_front();
          n_vec++;
          if (g != e_g || digest_s[g] !== e_d) begin
            n_fail++;
            $display("FAIL digest dut%0d: got %h expected %h (from dut%0d)", g, digest_s[g], e_d, e_g);
          end
          n_vec++;
          if (cyc - xfer_cyc[g] != e_l) begin
            n_fail++;
            $display("FAIL latency dut%0d: got %0d expected %0d", g, cyc - xfer_cyc[g], e_l);
          end
        end
      end
      ov_prev[g] = out_valid[g];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int g, input logic [511:0] b, input logic f, input logic l,
                      input logic m, input logic push, input logic [255:0] exp, input int lat);
    int n;
    @(negedge clk);
    block_s[g]  = b;
    first_s[g]  = f;
    last_s[g]   = l;
    mode_s[g]   = m;
    in_valid[g] = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      dut_q.push_back(g);
    end
    n = 0;
    while (in_ready[g] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout dut%0d: in_ready got 0 expected 1 within 200 cycles", g);
    end
    @(negedge clk);
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_ready[g] !== 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout dut%0d: pending %0d expected 0", g, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0; block_s[g] = '0; first_s[g] = 1'b0; last_s[g] = 1'b0;
      mode_s[g] = 1'b0; abort_s[g] = 1'b0; out_ready[g] = 1'b1; ov_prev[g] = 1'b0;
      xfer_cyc[g] = 0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(in_ready[0]), 256'(0));
    check("rst_out_valid", 256'(out_valid[0]), 256'(0));
    check("rst_digest", digest_s[0], 256'(0));
    rst_n = 1'b1;
    check("in_ready_at_release", 256'(in_ready[0]), 256'(0));
    @(negedge clk);
    check("in_ready_first_clk", 256'(in_ready[0]), 256'(1));

    // Single-block "abc"
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b1, ABC256, 66);
    wait_done(0);

    // Two-block message on each rounds-per-cycle variant
    for (int g = 0; g < 3; g++) begin
      send(g, B1_BLK, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
      wait_done(g);
      send(g, B2_BLK, 1'b0, 1'b1, 1'b0, 1'b1, TWO256, 64 / (1 << g) + 2);
      wait_done(g);
    end

    // mode_224 request
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b1, 1'b1, ABC_M224, 66);
    wait_done(0);

    // Consumer stall: digest must hold while out_ready is low
    out_ready[0] = 1'b0;
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b1, ABC256, 66);
    n = 0;
    while (out_valid[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", 256'(out_valid[0]), 256'(1));
      check("stall_digest", digest_s[0], ABC256);
      check("stall_in_ready", 256'(in_ready[0]), 256'(0));
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("release_in_ready", 256'(in_ready[0]), 256'(1));
    check("release_out_valid", 256'(out_valid[0]), 256'(0));

    // Abort mid-COMP: no output, H cleared, then a clean hash
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0);
    repeat (19) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort_in_ready", 256'(in_ready[0]), 256'(1));
    check("abort_out_valid", 256'(out_valid[0]), 256'(0));
    check("abort_digest", digest_s[0], 256'(0));
    repeat (80) @(negedge clk);
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b1, ABC256, 66);
    wait_done(0);

    // Asynchronous reset mid-COMP
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_digest", digest_s[0], 256'(0));
    check("async_rst_out_valid", 256'(out_valid[0]), 256'(0));
    check("async_rst_in_ready", 256'(in_ready[0]), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, ABC_BLK, 1'b1, 1'b1, 1'b0, 1'b1, ABC256, 66);
    wait_done(0);

    repeat (5) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_core_gen.md
SHA256_CORE_GEN -- requirements
Module: sha256_core_gen

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, meaning compression rounds per clock (legal values 1, 2, 4); other values are a elaboration error.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  block offered.
REQ-005 SHALL have port in_ready  output  1  core accepts a block this cycle.
REQ-006 SHALL have port block_in  input  512  message block, word 0 at [511:480].
REQ-007 SHALL have port first  input  1  start a new message with the IV; 0 chains from the held state.
REQ-008 SHALL have port last  input  1  block is the final block of the message.
REQ-009 SHALL have port mode_224  input  1  select SHA-224 IV/truncation; sampled only with first=1.
REQ-010 SHALL have port abort  input  1  synchronous cancel of the current message.
REQ-011 SHALL have port out_valid  output  1  digest valid.
REQ-012 SHALL have port out_ready  input  1  digest consumer ready.
REQ-013 SHALL have port digest  output  256  H0..H7, H0 at [255:224].

Function
REQ-014 SHALL use states IDLE, COMP, FINAL, OUT.
REQ-015 SHALL assert in_ready only in IDLE; transfer occurs on in_valid&&in_ready; block_in, first, last, mode_224 are captured on that edge.
REQ-016 SHALL on transfer load the message schedule (16-word circular buffer) and working vars from the IV (first=1) or the held H (first=0), then enter COMP.
REQ-017 SHALL in COMP perform ROUNDS_PER_CYCLE rounds per cycle for 64/ROUNDS_PER_CYCLE cycles, then enter FINAL.
REQ-018 SHALL in FINAL add working vars to H modulo 2^32 per word; go to OUT if last, else IDLE.
REQ-019 SHALL assert out_valid in OUT; hold digest stable until out_valid&&out_ready, then return to IDLE (one-cycle bubble before next in_ready).
REQ-020 SHALL give latency from transfer edge to out_valid of 64/ROUNDS_PER_CYCLE+2 cycles (66 at default).
REQ-021 SHALL in SHA-224 mode drive digest[31:0] to zero and keep H7 internal for chaining.
REQ-022 SHALL on abort=1 in any state return to IDLE next cycle, deassert out_valid, clear H to zero; abort beats in_valid in the same cycle.
REQ-023 SHALL treat first=0 after reset or abort as chaining from the zero H (defined, not an error).
REQ-024 SHALL ignore in_valid outside IDLE and keep digest = H at all times (digest changes only in FINAL).

Reset
REQ-025 SHALL on rst_n low asynchronously force IDLE, in_ready=0 until first clock after release then 1, out_valid=0, digest=0, H, working vars, schedule, mode zero.
REQ-026 SHALL abandon any in-flight block when reset asserts mid-COMP; no partial digest is ever output.

Configuration
REQ-027 SHALL compile SHA-224 support only when macro SHA256_CORE_GEN_SHA224_EN is defined; without it mode_224 is ignored (treated 0), the SHA-224 IV and truncation logic are absent, port list unchanged.

Structure
REQ-028 SHALL place the 64 K constants, SHA-256 and SHA-224 IVs, state encoding, and ror/Sigma/sigma functions in shared package sha2_pkg.
REQ-029 SHALL implement one round as combinational sub-module sha2_round (inputs a..h, K, W; outputs next a..h), instantiated ROUNDS_PER_CYCLE times in chain.

Verification
REQ-030 SHALL check "abc" padded, first=1 last=1 mode_224=0, R=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid exactly 66 cycles after transfer.
REQ-031 SHALL check 2-block "abcdbcdecdefdefgefghfghighijhijkijkljklmnomnopnopq" (first=1/last=0, then first=0/last=1), R=1,2,4 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; latency 66/34/18.
REQ-032 SHALL check with macro defined, "abc" mode_224=1 -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000; without macro same stimulus -> SHA-256 "abc" digest.
REQ-033 SHALL check out_ready held low 10 cycles -> out_valid and digest stable, in_ready=0; release -> IDLE, in_ready=1 next cycle.
REQ-034 SHALL check abort at COMP cycle 20 -> IDLE next cycle, no out_valid; then "abc" first=1 -> correct SHA-256 digest.
REQ-035 SHALL check rst_n pulsed low mid-COMP -> outputs zero immediately, out_valid=0, clean "abc" hash afterwards.
